// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex->segment table and idle levels.
package seg7_pkg;

  localparam logic [3:0] SEL_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LOAD,
  output logic [3:0]  DISP_SEL_OUT,
  output logic [7:0]  DISP_OUT,
  output logic        FRAME_DONE
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      act_q, act_d;
  logic [19:0]      pend_q, pend_d;
  logic             pflag_q, pflag_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       out_q, out_d;
  logic             fd_q, fd_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       seg;
  logic             blank;

  assign nibble = act_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero
  assign blank = (idx_q != 2'd0) && ((act_q[15:0] >> {idx_q, 2'b00}) == 16'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == 2'd3);
    presc_d  = tick ? '0 : presc_q + CNT_W'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    act_d    = act_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    // Commit uses the pre-edge pending value, so a coincident LOAD waits a frame
    if (boundary && pflag_q) begin
      act_d   = pend_q;
      pflag_d = 1'b0;
    end
    if (LOAD) begin
      pend_d  = {DOTS_IN, DIGITS_IN};
      pflag_d = 1'b1;
    end
    sel_d = ~(4'b0001 << idx_q);
    out_d = {~act_q[5'd16 + {3'd0, idx_q}], blank ? 7'h7F : seg};
    fd_d  = boundary;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      act_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      sel_q   <= SEL_OFF;
      out_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      fd_q    <= fd_d;
    end
  end

  assign DISP_SEL_OUT = sel_q;
  assign DISP_OUT     = out_q;
  assign FRAME_DONE   = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random loads/resets
// checked every cycle against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DIGITS_IN;
  logic [3:0]  DOTS_IN;
  logic        LOAD;
  logic [3:0]  DISP_SEL_OUT;
  logic [7:0]  DISP_OUT;
  logic        FRAME_DONE;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DIGITS_IN    (DIGITS_IN),
    .DOTS_IN      (DOTS_IN),
    .LOAD         (LOAD),
    .DISP_SEL_OUT (DISP_SEL_OUT),
    .DISP_OUT     (DISP_OUT),
    .FRAME_DONE   (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [7:0] CODES [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: edges since reset release, displayed and pending words
  int          n_edges;
  logic [19:0] m_act, m_pend;
  bit          m_pflag;
  logic [3:0]  e_sel;
  logic [7:0]  e_out;
  logic        e_fd;
  logic [7:0]  disp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] digit_code(input logic [19:0] a, input int i);
    logic [7:0] c;
    bit blank;
    c = CODES[(a[15:0] >> (4 * i)) & 16'hF];
`ifdef SEG7_LZ_BLANK_EN
    blank = (i > 0) && ((a[15:0] >> (4 * i)) == 0);
`else
    blank = 0;
`endif
    return {~a[16 + i], blank ? 7'h7F : c[6:0]};
  endfunction

  task automatic step();
    int slot;
    @(posedge CLK);
    if (RESET) begin
      e_sel = 4'hF; e_out = 8'hFF; e_fd = 1'b0;
      n_edges = 0; m_act = '0; m_pend = '0; m_pflag = 0;
    end else begin
      slot  = (n_edges / DIV) % 4;
      e_fd  = ((n_edges % FRAME) == FRAME - 1);
      e_sel = 4'hF ^ (4'b0001 << slot);
      e_out = digit_code(m_act, slot);
      if (e_fd && m_pflag) begin
        m_act = m_pend;
        m_pflag = 0;
      end
      if (LOAD) begin
        m_pend = {DOTS_IN, DIGITS_IN};
        m_pflag = 1;
      end
      n_edges++;
    end
    #1;
    chk("model_sel", DISP_SEL_OUT, e_sel);
    chk("model_out", DISP_OUT, e_out);
    chk("model_fd", FRAME_DONE, e_fd);
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      step();
      k++;
    end while (FRAME_DONE !== 1'b1 && k < 40);
    if (FRAME_DONE !== 1'b1) chk("wait_frame_timeout", 0, 1);
  endtask

  // Records one full frame of digit codes; starts right after a FRAME_DONE
  task automatic capture(output int fd_cnt);
    fd_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (FRAME_DONE) fd_cnt++;
      for (int d = 0; d < 4; d++)
        if (DISP_SEL_OUT == (4'hF ^ (4'b0001 << d))) disp[d] = DISP_OUT;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    DIGITS_IN = v; DOTS_IN = dp; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    int fdc;
    int cnt [4];
    RESET = 1'b1; LOAD = 1'b0; DIGITS_IN = '0; DOTS_IN = '0;

    // 1. reset and release
    for (int i = 0; i < 10; i++) step();
    chk("rst_sel", DISP_SEL_OUT, 4'hF);
    chk("rst_out", DISP_OUT, 8'hFF);
    chk("rst_fd", FRAME_DONE, 1'b0);
    RESET = 1'b0;
    step();
    chk("rel_sel", DISP_SEL_OUT, 4'b1110);
    chk("rel_out", DISP_OUT, 8'hC0);

    // 2. load shows only after boundary
    do_load(16'h12AF, 4'b0000);
    chk("t2_hold", DISP_OUT, 8'hC0);
    wait_frame();
    capture(fdc);
    chk("t2_d0", disp[0], 8'h8E);
    chk("t2_d1", disp[1], 8'h88);
    chk("t2_d2", disp[2], 8'hA4);
    chk("t2_d3", disp[3], 8'hF9);
    chk("t2_fd_count", fdc, 1);

    // 3. last load in a frame wins
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    wait_frame();
    capture(fdc);
    chk("t3_d0", disp[0], 8'hA4);
    chk("t3_d3", disp[3], 8'hA4);

    // 4. load on the exact boundary cycle with nothing pending
    for (int i = 0; i < FRAME - 1; i++) step();
    do_load(16'h0005, 4'b0100);
    chk("t4_boundary", FRAME_DONE, 1'b1);
    capture(fdc);
    chk("t4_old_d0", disp[0], 8'hA4);
    capture(fdc);
    chk("t4_d0", disp[0], 8'h92);
`ifdef SEG7_LZ_BLANK_EN
    chk("t4_d1", disp[1], 8'hFF);
    chk("t4_d2", disp[2], 8'h7F);
    chk("t4_d3", disp[3], 8'hFF);
`else
    chk("t4_d1", disp[1], 8'hC0);
    chk("t4_d2", disp[2], 8'h40);
    chk("t4_d3", disp[3], 8'hC0);
`endif

    // 5. reset mid-frame with a pending value
    do_load(16'h9876, 4'b1111);
    for (int i = 0; i < 8; i++) step();
    RESET = 1'b1;
    step();
    chk("t5_sel", DISP_SEL_OUT, 4'hF);
    chk("t5_out", DISP_OUT, 8'hFF);
    RESET = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("t5_zero", DISP_OUT, 8'hC0);
    end

    // 6. one-cold anodes and equal dwell
    for (int d = 0; d < 4; d++) cnt[d] = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("t6_onecold", $countones(~DISP_SEL_OUT), 1);
      for (int d = 0; d < 4; d++)
        if (DISP_SEL_OUT == (4'hF ^ (4'b0001 << d))) cnt[d]++;
    end
    for (int d = 0; d < 4; d++) chk("t6_dwell", cnt[d], 16);

    // random loads and occasional resets, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      DIGITS_IN = 16'($urandom);
      DOTS_IN   = 4'($urandom);
      LOAD      = ($urandom_range(0, 5) == 0);
      RESET     = ($urandom_range(0, 149) == 0);
      step();
    end
    RESET = 1'b0; LOAD = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
